// File: rtl/riscv_multicycle_ctrl_pkg.sv
// Shared definitions for the RV64 multi-cycle controller: opcodes, state
// encodings, ALU operand/operation selects and the datapath control bundle.
package riscv_multicycle_ctrl_pkg;

  // Major opcodes (IR[6:0]) understood by the controller.
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ALU B operand select.
  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH1 = 2'b11;

  // Operation class handed to the ALU control unit.
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // State encodings are visible on the debug port, so they are fixed values.
  typedef enum logic [3:0] {
    ST_RST      = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_MEM_ADDR = 4'd3,
    ST_MEM_RD   = 4'd4,
    ST_MEM_WB   = 4'd5,
    ST_MEM_WR   = 4'd6,
    ST_EXEC_R   = 4'd7,
    ST_EXEC_I   = 4'd8,
    ST_ALU_WB   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_HALT     = 4'd15
  } state_t;

  // Per-cycle datapath control bundle produced by the output decode.
  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_source;
    logic       retire;
    logic       halted;
  } ctrl_t;

  // States that stall on the shared memory port until mem_ready.
  function automatic logic is_mem_wait(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/riscv_multicycle_ctrl_mem_wait_timer.sv
// Counts consecutive not-ready cycles spent in a memory-wait state and flags
// the cycle in which the controller must give up and halt.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic wait_en,
  input  logic clr,
  output logic expired
);

  localparam int unsigned W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam bit ENABLED = (TIMEOUT_CYCLES != 0);
  // A zero timeout disables the limit; the counter then just free-runs.
  localparam logic [W-1:0] LIMIT = W'(ENABLED ? TIMEOUT_CYCLES - 1 : 0);

  logic [W-1:0] cnt;

  // Wait counter: cleared on leaving the wait or on ready, else counts stalls.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block evaluation order.
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (wait_en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Expiry: the last tolerated not-ready cycle is stalling again.
  always_comb begin
    expired = ENABLED && wait_en && (cnt == LIMIT);
  end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle main control FSM for the RV64 datapath. Sequences fetch,
// decode, execute, memory and writeback over one shared memory port, stalls
// on mem_ready, and halts on an illegal opcode or a memory timeout.
module riscv_multicycle_ctrl
  import riscv_multicycle_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       alu_zero,
  output logic       pc_write,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       pc_source,
  output logic       retire,
  output logic       halted,
  output logic       mem_err,
  output logic [3:0] state_o
);

  state_t state;
  state_t state_next;
  ctrl_t  ctrl;
  logic   wait_en;
  logic   wait_clr;
  logic   timeout;

  // A stall cycle is a memory-wait state whose access did not complete.
  assign wait_en  = is_mem_wait(state) && !mem_ready;
  assign wait_clr = mem_ready || (state_next != state);

  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .wait_en(wait_en),
    .clr    (wait_clr),
    .expired(timeout)
  );

  // State register; reset aborts any in-flight instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RST;
    end else begin
      state <= state_next;
    end
  end

  // Sticky fault flag, raised only when a memory wait times out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_err <= 1'b0;
    end else if (timeout) begin
      mem_err <= 1'b1;
    end
  end

  // Next-state and control decode from the current state and qualifiers.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch
    // is inferred; each state then raises only the controls it needs.
    ctrl       = '0;
    state_next = state;

    case (state)
      ST_RST: begin
        state_next = ST_FETCH;
      end

      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
        if (mem_ready) begin
          state_next = ST_DECODE;
        end else if (timeout) begin
          state_next = ST_HALT;
        end
      end

      ST_DECODE: begin
        // Precompute the branch target into ALUOut while decoding.
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRC_B_IMM_SH1;
        ctrl.alu_op    = ALU_OP_ADD;
        case (opcode)
          OP_RTYPE:          state_next = ST_EXEC_R;
          OP_ITYPE:          state_next = ST_EXEC_I;
          OP_LOAD, OP_STORE: state_next = ST_MEM_ADDR;
          OP_BRANCH:         state_next = ST_BRANCH;
          default:           state_next = ST_HALT;
        endcase
      end

      ST_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
        state_next     = (opcode == OP_STORE) ? ST_MEM_WR : ST_MEM_RD;
      end

      ST_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
        if (mem_ready) begin
          state_next = ST_MEM_WB;
        end else if (timeout) begin
          state_next = ST_HALT;
        end
      end

      ST_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.retire     = 1'b1;
        state_next      = ST_FETCH;
      end

      ST_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
        ctrl.retire    = mem_ready;
        if (mem_ready) begin
          state_next = ST_FETCH;
        end else if (timeout) begin
          state_next = ST_HALT;
        end
      end

      ST_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALU_OP_FUNCT;
        state_next     = ST_ALU_WB;
      end

      ST_EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
        state_next     = ST_ALU_WB;
      end

      ST_ALU_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.retire    = 1'b1;
        state_next     = ST_FETCH;
      end

      ST_BRANCH: begin
        // Compare in the ALU; take the precomputed target from ALUOut.
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALU_OP_SUB;
        ctrl.pc_source = 1'b1;
        ctrl.pc_write  = alu_zero;
        ctrl.retire    = 1'b1;
        state_next     = ST_FETCH;
      end

      ST_HALT: begin
        ctrl.halted = 1'b1;
        state_next  = ST_HALT;
      end

      default: begin
        // Unused encodings are treated as a fault and park in HALT.
        state_next = ST_HALT;
      end
    endcase
  end

  assign pc_write   = ctrl.pc_write;
  assign ir_write   = ctrl.ir_write;
  assign i_or_d     = ctrl.i_or_d;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_write  = ctrl.reg_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_source  = ctrl.pc_source;
  assign retire     = ctrl.retire;
  assign halted     = ctrl.halted;
  assign state_o    = state;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed self-checking bench for riscv_multicycle_ctrl (TIMEOUT_CYCLES=4).
module tb_riscv_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       alu_zero;
  logic       pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg;
  logic       reg_write, alu_src_a, pc_source, retire, halted, mem_err;
  logic [1:0] alu_src_b, alu_op;
  logic [3:0] state_o;
  logic [15:0] outs;

  int n_assert   = 0;
  int n_fail     = 0;
  int cyc        = 0;
  int retire_cnt = 0;
  int c0         = 0;

  // Opcodes and state numbers written out independently of the RTL package.
  localparam logic [6:0] R_OP = 7'b0110011, I_OP = 7'b0010011, LD_OP = 7'b0000011;
  localparam logic [6:0] SD_OP = 7'b0100011, BR_OP = 7'b1100011, BAD_OP = 7'b1111111;

  // Output vector layout:
  // pc_write ir_write i_or_d mem_read | mem_write mem_to_reg reg_write src_a |
  // src_b[1:0] alu_op[1:0] | pc_source retire halted mem_err
  localparam logic [15:0] O_ZERO     = 16'b0000_0000_0000_0000;
  localparam logic [15:0] O_FETCH_RD = 16'b1101_0000_0100_0000;
  localparam logic [15:0] O_FETCH_WT = 16'b0001_0000_0100_0000;
  localparam logic [15:0] O_DECODE   = 16'b0000_0000_1100_0000;
  localparam logic [15:0] O_EXEC_R   = 16'b0000_0001_0010_0000;
  localparam logic [15:0] O_EXEC_I   = 16'b0000_0001_1000_0000;
  localparam logic [15:0] O_MEM_ADDR = 16'b0000_0001_1000_0000;
  localparam logic [15:0] O_ALU_WB   = 16'b0000_0010_0000_0100;
  localparam logic [15:0] O_MEM_RD   = 16'b0011_0000_0000_0000;
  localparam logic [15:0] O_MEM_WB   = 16'b0000_0110_0000_0100;
  localparam logic [15:0] O_MEM_WR_W = 16'b0010_1000_0000_0000;
  localparam logic [15:0] O_MEM_WR_R = 16'b0010_1000_0000_0100;
  localparam logic [15:0] O_BR_TAKEN = 16'b1000_0001_0001_1100;
  localparam logic [15:0] O_BR_NOT   = 16'b0000_0001_0001_1100;
  localparam logic [15:0] O_HALT     = 16'b0000_0000_0000_0010;
  localparam logic [15:0] O_HALT_ERR = 16'b0000_0000_0000_0011;

  assign outs = {pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
                 reg_write, alu_src_a, alu_src_b, alu_op, pc_source, retire,
                 halted, mem_err};

  riscv_multicycle_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .alu_zero  (alu_zero),
    .pc_write  (pc_write),
    .ir_write  (ir_write),
    .i_or_d    (i_or_d),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_to_reg(mem_to_reg),
    .reg_write (reg_write),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .alu_op    (alu_op),
    .pc_source (pc_source),
    .retire    (retire),
    .halted    (halted),
    .mem_err   (mem_err),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Retire pulses are counted mid-cycle, away from the state update.
  always @(negedge clk) if (retire) retire_cnt++;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic see(input string tag, input logic [3:0] st, input logic [15:0] o);
    #1;
    chk({tag, " state"}, {12'd0, state_o}, {12'd0, st});
    chk({tag, " outs"}, outs, o);
  endtask

  task automatic adv();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; opcode = R_OP; mem_ready = 1'b1; alu_zero = 1'b0;

    // 1. Reset, then an R-type with memory always ready.
    #12;
    see("reset", 4'd0, O_ZERO);
    #4 reset = 1'b0;
    see("released", 4'd0, O_ZERO);
    adv(); see("r fetch", 4'd1, O_FETCH_RD);
    c0 = cyc;
    adv(); see("r decode", 4'd2, O_DECODE);
    adv(); see("r exec", 4'd7, O_EXEC_R);
    adv(); see("r wb", 4'd9, O_ALU_WB);
    adv(); see("r done", 4'd1, O_FETCH_RD);
    chk("r latency", 16'(cyc - c0), 16'd4);

    // 2. Load with three not-ready cycles in MEM_RD.
    opcode = LD_OP; c0 = cyc;
    adv(); see("ld decode", 4'd2, O_DECODE);
    adv(); see("ld addr", 4'd3, O_MEM_ADDR);
    mem_ready = 1'b0;
    adv(); see("ld rd wait1", 4'd4, O_MEM_RD);
    adv(); see("ld rd wait2", 4'd4, O_MEM_RD);
    adv(); see("ld rd wait3", 4'd4, O_MEM_RD);
    adv(); mem_ready = 1'b1; see("ld rd ready", 4'd4, O_MEM_RD);
    adv(); see("ld wb", 4'd5, O_MEM_WB);
    adv(); see("ld done", 4'd1, O_FETCH_RD);
    chk("ld latency", 16'(cyc - c0), 16'd8);

    // I-type.
    opcode = I_OP; c0 = cyc;
    adv(); see("i decode", 4'd2, O_DECODE);
    adv(); see("i exec", 4'd8, O_EXEC_I);
    adv(); see("i wb", 4'd9, O_ALU_WB);
    adv(); see("i done", 4'd1, O_FETCH_RD);
    chk("i latency", 16'(cyc - c0), 16'd4);

    // 3. Branch taken, then not taken.
    opcode = BR_OP; c0 = cyc;
    adv(); see("beq1 decode", 4'd2, O_DECODE);
    alu_zero = 1'b1;
    adv(); see("beq taken", 4'd10, O_BR_TAKEN);
    adv(); see("beq1 done", 4'd1, O_FETCH_RD);
    chk("beq latency", 16'(cyc - c0), 16'd3);
    adv(); see("beq2 decode", 4'd2, O_DECODE);
    alu_zero = 1'b0;
    adv(); see("beq not taken", 4'd10, O_BR_NOT);
    adv(); see("beq2 done", 4'd1, O_FETCH_RD);

    // Store with one not-ready cycle in MEM_WR.
    opcode = SD_OP; c0 = cyc;
    adv(); see("sd decode", 4'd2, O_DECODE);
    adv(); see("sd addr", 4'd3, O_MEM_ADDR);
    mem_ready = 1'b0;
    adv(); see("sd wr wait", 4'd6, O_MEM_WR_W);
    adv(); mem_ready = 1'b1; see("sd wr ready", 4'd6, O_MEM_WR_R);
    adv(); see("sd done", 4'd1, O_FETCH_RD);
    chk("sd latency", 16'(cyc - c0), 16'd5);

    // 4. Timeout: four not-ready FETCH cycles, then HALT with mem_err.
    mem_ready = 1'b0;
    see("to fetch1", 4'd1, O_FETCH_WT);
    adv(); see("to fetch2", 4'd1, O_FETCH_WT);
    adv(); see("to fetch3", 4'd1, O_FETCH_WT);
    adv(); see("to fetch4", 4'd1, O_FETCH_WT);
    adv(); see("to halt", 4'd15, O_HALT_ERR);
    reset = 1'b1;
    see("to reset clears err", 4'd0, O_ZERO);
    #2 reset = 1'b0;

    // Variant: ready arrives on the fourth FETCH cycle.
    adv(); see("var fetch1", 4'd1, O_FETCH_WT);
    adv(); see("var fetch2", 4'd1, O_FETCH_WT);
    adv(); see("var fetch3", 4'd1, O_FETCH_WT);
    adv(); mem_ready = 1'b1; see("var fetch4 ready", 4'd1, O_FETCH_RD);

    // 5. Illegal opcode halts without mem_err and stays halted.
    opcode = BAD_OP;
    adv(); see("var decode", 4'd2, O_DECODE);
    adv(); see("bad halt", 4'd15, O_HALT);
    for (int i = 0; i < 20; i++) begin
      adv(); see("bad halt hold", 4'd15, O_HALT);
    end
    reset = 1'b1;
    see("bad reset", 4'd0, O_ZERO);
    #2 reset = 1'b0;
    opcode = SD_OP;
    adv(); see("bad restart", 4'd1, O_FETCH_RD);

    // 6. Asynchronous reset in the middle of a stalled store.
    adv(); see("ab decode", 4'd2, O_DECODE);
    adv(); see("ab addr", 4'd3, O_MEM_ADDR);
    mem_ready = 1'b0;
    adv(); see("ab wr wait", 4'd6, O_MEM_WR_W);
    reset = 1'b1;
    see("ab async reset", 4'd0, O_ZERO);
    adv(); see("ab held", 4'd0, O_ZERO);
    reset = 1'b0;
    adv(); see("ab fetch", 4'd1, O_FETCH_WT);

    // R, load, I, two branches and one completed store retire; the aborted store does not.
    chk("retire count", 16'(retire_cnt), 16'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
